// File: rtl/multiword_add_ctrl.sv
// Multi-limb add/subtract sequencer driving one shared 16-bit adder, LS limb first.
// Optional build macro MULTIADD_ACCUM_EN adds the acc port (A operand taken from result).
module multiword_add_ctrl #(
    parameter int WORDS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic                sub,
`ifdef MULTIADD_ACCUM_EN
    input  logic                acc,
`endif
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] result,
    output logic                carry_out,
    output logic                overflow,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_s,
    input  logic                add_cout
);
    localparam int W  = 16*WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            cout_q, cout_d, ovf_q, ovf_d;
    logic [15:0]     limb_a, limb_b;
    logic            last;
    logic [W-1:0]    a_src;

`ifdef MULTIADD_ACCUM_EN
    assign a_src = acc ? res_q : op_a;
`else
    assign a_src = op_a;
`endif

    assign last = (idx_q == IW'(WORDS-1));

    always_comb begin
        limb_a = '0;
        limb_b = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IW'(w)) begin
                limb_a = a_q[16*w +: 16];
                limb_b = b_q[16*w +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B once here, seed carry with sub.
                    a_d     = a_src;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = limb_a;
                add_b   = limb_b;
                add_cin = carry_q;
                carry_d = add_cout;
                for (int w = 0; w < WORDS; w++) begin
                    if (idx_q == IW'(w)) res_d[16*w +: 16] = add_s;
                end
                if (last) begin
                    cout_d  = add_cout;
                    ovf_d   = (limb_a[15] == limb_b[15]) && (add_s[15] != limb_a[15]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = res_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Directed + random bench for multiword_add_ctrl; the shared adder and a full-width
// arithmetic reference live here.
module tb_multiword_add_ctrl;
    localparam int WORDS = 4;
    localparam int W     = 16*WORDS;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start, sub;
    logic [W-1:0]  op_a, op_b;
    logic          busy, done, carry_out, overflow;
    logic [W-1:0]  result;
    logic [15:0]   add_a, add_b, add_s;
    logic          add_cin, add_cout;
`ifdef MULTIADD_ACCUM_EN
    logic          acc;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_res;

    multiword_add_ctrl #(.WORDS(WORDS)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .sub(sub),
`ifdef MULTIADD_ACCUM_EN
        .acc(acc),
`endif
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .add_a(add_a), .add_b(add_b),
        .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
    );

    always #5 Clk = ~Clk;

    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic drive(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ac);
        start = st; op_a = a; op_b = b; sub = s;
`ifdef MULTIADD_ACCUM_EN
        acc = ac;
`else
        if (ac) checks = checks;
`endif
    endtask

    // pre=1: start already driven by the previous hold-mode call.
    // hold=1: keep start asserted with junk through RUN and DONE, then queue (na,nb,ns).
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic acc_v, input bit pre, input bit hold,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
        logic [W-1:0]          aeff, beff;
        logic [W:0]            full, mask, lo;
        logic signed [W+1:0]   sv;
        logic                  exp_ovf;
        aeff = acc_v ? exp_res : a;
        beff = s ? ~b : b;
        full = {1'b0, aeff} + {1'b0, beff} + (W+1)'(s);
        if (s) sv = $signed({{2{aeff[W-1]}}, aeff}) - $signed({{2{b[W-1]}}, b});
        else   sv = $signed({{2{aeff[W-1]}}, aeff}) + $signed({{2{b[W-1]}}, b});
        exp_ovf = (sv[W+1:W-1] != 3'b000) && (sv[W+1:W-1] != 3'b111);
        if (!pre) begin
            @(negedge Clk);
            drive(1'b1, a, b, s, acc_v);
        end
        @(posedge Clk); #1;
        for (int k = 0; k < WORDS; k++) begin
            mask = ((W+1)'(1) << (16*k)) - 1;
            lo   = ({1'b0, aeff} & mask) + ({1'b0, beff} & mask) + (W+1)'(s);
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            chk("add_a", add_a, aeff[16*k +: 16]);
            chk("add_b", add_b, beff[16*k +: 16]);
            chk("add_cin", add_cin, lo[16*k]);
            drive(hold, rnd64(), rnd64(), 1'($urandom_range(1)), 1'($urandom_range(1)));
            @(posedge Clk); #1;
        end
        chk("busy_done", busy, 0);
        chk("done_pulse", done, 1);
        chk("add_a_done", add_a, 0);
        chk("add_cin_done", add_cin, 0);
        chk("result", result, full[W-1:0]);
        chk("carry_out", carry_out, full[W]);
        chk("overflow", overflow, exp_ovf);
        @(posedge Clk); #1;
        chk("done_width", done, 0);
        chk("busy_after", busy, 0);
        chk("result_hold", result, full[W-1:0]);
        exp_res = full[W-1:0];
        if (hold) drive(1'b1, na, nb, ns, 1'b0);
        else      drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        exp_res = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_add_a", add_a, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0);
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0);
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0);
        do_op(64'h5, 64'h7, 1'b1, 1'b0, 0, 0, '0, '0, 1'b0);

        // start held through RUN/DONE is ignored; next start right after DONE is taken
        do_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 1,
              64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0);
        do_op(64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1, 0,
              '0, '0, 1'b0);

        // asynchronous reset mid-RUN at idx=2
        @(negedge Clk);
        drive(1'b1, rnd64(), rnd64(), 1'b0, 1'b0);
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end
        chk("mid_busy", busy, 1);
        #2 Reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_cout", carry_out, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_add_a", add_a, 0);
        chk("arst_done", done, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        exp_res = '0;
        repeat (6) begin
            @(negedge Clk);
            chk("arst_no_done", done, 0);
        end
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] ra, rb;
            ra = rnd64();
            rb = (i % 4 == 3) ? ~ra : rnd64();
            do_op(ra, rb, 1'($urandom_range(1)), 1'b0, 0, 0, '0, '0, 1'b0);
        end

`ifdef MULTIADD_ACCUM_EN
        do_op(64'd10, 64'd3, 1'b0, 1'b0, 0, 0, '0, '0, 1'b0);
        do_op(rnd64(), 64'd4, 1'b0, 1'b1, 0, 0, '0, '0, 1'b0);
        chk("accum_17", result, 64'd17);
        do_op(rnd64(), 64'd20, 1'b1, 1'b1, 0, 0, '0, '0, 1'b0);
        chk("accum_neg3", result, 64'hFFFF_FFFF_FFFF_FFFD);
        for (int i = 0; i < 4; i++)
            do_op(rnd64(), rnd64(), 1'($urandom_range(1)), 1'b1, 0, 0, '0, '0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
